// File: rtl/blink_round_ctrl.sv
// Round sequencer for the Blink reaction game.
//
// Each round keeps the LED dark for WAIT_CYC cycles, then lights it for a
// WIN_CYC-cycle response window. A press in the window wins the round; a press
// while dark (false start) or no press at all loses it. Every round ends in a
// one-cycle JUDGE state that strobes the decision to the loss register. Wins
// chain straight into the next round; a loss parks in OVER until a new start.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   start     in   begin a new game (only honoured in IDLE or OVER)
//   btn       in   synchronized/debounced player press
//   led       out  high while the response window is open
//   dec_d     out  decision to the loss register (1 = win, 0 = lose)
//   dec_en    out  one-cycle write strobe to the loss register
//   score     out  rounds won in the current game, saturating
//   busy      out  high while a round is in progress (WAIT, LIT, JUDGE)
//   game_over out  high in OVER
module blink_round_ctrl #(
  parameter int unsigned WAIT_CYC = 16,
  parameter int unsigned WIN_CYC  = 8,
  parameter int unsigned SCORE_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               btn,
  output logic               led,
  output logic               dec_d,
  output logic               dec_en,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               game_over
);

  localparam int unsigned MaxCyc = (WAIT_CYC > WIN_CYC) ? WAIT_CYC : WIN_CYC;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [CntW-1:0] WaitLast = CntW'(WAIT_CYC - 1);
  localparam logic [CntW-1:0] WinLast  = CntW'(WIN_CYC - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWait  = 3'd1;
  localparam logic [2:0] StLit   = 3'd2;
  localparam logic [2:0] StJudge = 3'd3;
  localparam logic [2:0] StOver  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               result_q, result_d;
  logic [SCORE_W-1:0] score_q, score_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    score_d  = score_q;

    case (state_q)
      StIdle, StOver: begin
        if (start) begin
          state_d = StWait;
          cnt_d   = '0;
          score_d = '0;
        end
      end

      StWait: begin
        // A press beats expiry, even on the final dark cycle.
        if (btn) begin
          state_d  = StJudge;
          result_d = 1'b0;
          cnt_d    = '0;
        end else if (cnt_q == WaitLast) begin
          state_d = StLit;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StLit: begin
        // A press on the final lit cycle still wins.
        if (btn) begin
          state_d  = StJudge;
          result_d = 1'b1;
          cnt_d    = '0;
        end else if (cnt_q == WinLast) begin
          state_d  = StJudge;
          result_d = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StJudge: begin
        if (result_q) begin
          state_d = StWait;
          cnt_d   = '0;
          if (score_q != {SCORE_W{1'b1}}) begin
            score_d = score_q + 1'b1;
          end
        end else begin
          state_d = StOver;
        end
      end

      default: begin
        state_d  = StIdle;
        cnt_d    = '0;
        result_d = 1'b0;
        score_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      result_q <= 1'b0;
      score_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      score_q  <= score_d;
    end
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    led       = (state_q == StLit);
    dec_en    = (state_q == StJudge);
    dec_d     = (state_q == StJudge) & result_q;
    busy      = (state_q == StWait) | (state_q == StLit) | (state_q == StJudge);
    game_over = (state_q == StOver);
    score     = score_q;
  end

endmodule

// File: tb/tb_blink_round_ctrl.sv
module tb_blink_round_ctrl;

  localparam int WaitCyc = 16;
  localparam int WinCyc  = 8;
  localparam int ScoreW  = 4;
  localparam int ScoreMax = (1 << ScoreW) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              btn;
  logic              led;
  logic              dec_d;
  logic              dec_en;
  logic [ScoreW-1:0] score;
  logic              busy;
  logic              game_over;

  int n_checks = 0;
  int n_fails  = 0;

  blink_round_ctrl #(
    .WAIT_CYC(WaitCyc),
    .WIN_CYC (WinCyc),
    .SCORE_W (ScoreW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .btn      (btn),
    .led      (led),
    .dec_d    (dec_d),
    .dec_en   (dec_en),
    .score    (score),
    .busy     (busy),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: the game as phases with a countdown of cycles left.
  // phase: 0 idle, 1 dark, 2 lit, 3 judging, 4 game over
  int m_phase = 0;
  int m_left  = 0;
  bit m_win   = 1'b0;
  int m_score = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase <= 0;
      m_left  <= 0;
      m_win   <= 1'b0;
      m_score <= 0;
    end else begin
      case (m_phase)
        0, 4: if (start) begin
          m_phase <= 1;
          m_left  <= WaitCyc;
          m_score <= 0;
        end
        1: if (btn) begin
          m_win   <= 1'b0;
          m_phase <= 3;
        end else if (m_left == 1) begin
          m_phase <= 2;
          m_left  <= WinCyc;
        end else begin
          m_left <= m_left - 1;
        end
        2: if (btn) begin
          m_win   <= 1'b1;
          m_phase <= 3;
        end else if (m_left == 1) begin
          m_win   <= 1'b0;
          m_phase <= 3;
        end else begin
          m_left <= m_left - 1;
        end
        default: if (m_win) begin
          m_score <= (m_score < ScoreMax) ? m_score + 1 : ScoreMax;
          m_phase <= 1;
          m_left  <= WaitCyc;
        end else begin
          m_phase <= 4;
        end
      endcase
    end
  end

  // Every cycle, away from the active edge, the DUT must match the model.
  always @(negedge clk) begin
    chk("model_led", led, (m_phase == 2));
    chk("model_dec_en", dec_en, (m_phase == 3));
    chk("model_dec_d", dec_d, (m_phase == 3) && m_win);
    chk("model_busy", busy, (m_phase >= 1 && m_phase <= 3));
    chk("model_game_over", game_over, (m_phase == 4));
    chk("model_score", score, m_score);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Ticks while led equals 'want', returning how many cycles that lasted.
  task automatic count_while(input logic want, output int n);
    n = 0;
    while (led === want && n < 64) begin
      n++;
      tick();
    end
    if (n >= 64) chk("led_wait_bound", n, 0);
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0;
    start = 1'b0;
    btn   = 1'b0;
    repeat (2) tick();
    chk("reset_led", led, 0);
    chk("reset_busy", busy, 0);
    chk("reset_score", score, 0);
    reset = 1'b1;
    repeat (3) tick();
    chk("idle_no_start_busy", busy, 0);

    // Win on the 3rd lit cycle, then a timeout loss in the next round.
    start_game();
    count_while(1'b0, n);
    chk("first_dark_len", n, WaitCyc);
    repeat (2) tick();
    btn = 1'b1;
    tick();
    chk("win_dec_en", dec_en, 1);
    chk("win_dec_d", dec_d, 1);
    btn = 1'b0;
    tick();
    chk("win_strobe_one_cycle", dec_en, 0);
    chk("win_score", score, 1);
    count_while(1'b0, n);
    chk("dark_after_win", n, WaitCyc);
    count_while(1'b1, n);
    chk("timeout_lit_len", n, WinCyc);
    chk("timeout_dec_en", dec_en, 1);
    chk("timeout_dec_d", dec_d, 0);
    tick();
    chk("timeout_over", game_over, 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_score_held", score, 1);

    // Restart from OVER clears the score and enters WAIT at once.
    start_game();
    chk("restart_busy", busy, 1);
    chk("restart_score", score, 0);
    chk("restart_not_over", game_over, 0);

    // False start on dark cycle 5.
    repeat (4) tick();
    btn = 1'b1;
    tick();
    chk("fs5_dec_en", dec_en, 1);
    chk("fs5_dec_d", dec_d, 0);
    btn = 1'b0;
    tick();
    chk("fs5_over", game_over, 1);

    // False start on the last dark cycle: press beats expiry.
    start_game();
    repeat (WaitCyc - 1) tick();
    chk("fs16_still_dark", led, 0);
    btn = 1'b1;
    tick();
    chk("fs16_dec_en", dec_en, 1);
    chk("fs16_dec_d", dec_d, 0);
    btn = 1'b0;
    tick();
    chk("fs16_over", game_over, 1);

    // Press on the last lit cycle wins; holding it through JUDGE is a false start.
    start_game();
    count_while(1'b0, n);
    repeat (WinCyc - 1) tick();
    chk("last_lit_led", led, 1);
    btn = 1'b1;
    tick();
    chk("last_lit_dec_d", dec_d, 1);
    tick();
    chk("held_btn_wait", busy, 1);
    tick();
    chk("held_btn_dec_en", dec_en, 1);
    chk("held_btn_dec_d", dec_d, 0);
    btn = 1'b0;
    tick();
    chk("held_btn_over", game_over, 1);

    // 17 straight wins saturate the score; start mid-round is ignored.
    start_game();
    for (int i = 0; i < 17; i++) begin
      if (i == 0) start_game();
      count_while(1'b0, n);
      chk("sat_dark_len", n, (i == 0) ? WaitCyc - 1 : WaitCyc);
      if (i == 0) begin
        start_game();
        chk("start_in_lit_ignored", led, 1);
      end
      btn = 1'b1;
      tick();
      chk("sat_dec_d", dec_d, 1);
      btn = 1'b0;
      tick();
    end
    chk("sat_score", score, ScoreMax);

    // Asynchronous reset in the middle of the lit window.
    count_while(1'b0, n);
    repeat (2) tick();
    #2 reset = 1'b0;
    #1;
    chk("async_rst_led", led, 0);
    chk("async_rst_dec_en", dec_en, 0);
    chk("async_rst_score", score, 0);
    chk("async_rst_busy", busy, 0);
    tick();
    reset = 1'b1;
    repeat (5) tick();
    chk("post_rst_idle_busy", busy, 0);
    chk("post_rst_idle_over", game_over, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/blink_round_ctrl.md
Name: blink_round_ctrl

Overview:
- Round sequencer for the Blink reaction game.
- Times each round: dark wait, then lit response window. Judges the player's button press and produces the win/lose decision.
- Drives the loss-decision register through `dec_d` (1 = win, 0 = lose) and a one-cycle `dec_en` strobe.
- Keeps a per-game score and holds game-over until a new start.

Parameters:
- WAIT_CYC, 16, cycles LED stays dark before lighting; must be >= 1.
- WIN_CYC, 8, cycles LED stays lit (response window); must be >= 1.
- SCORE_W, 4, width of the saturating win counter.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  begin new game; sampled only in IDLE or OVER.
- btn  in  1  player press, already synchronized/debounced; sampled every rising edge.
- led  out  1  1 while response window is open.
- dec_d  out  1  decision value to loss register D (1 = win, 0 = lose); 0 outside JUDGE.
- dec_en  out  1  one-cycle enable strobe to loss register.
- score  out  SCORE_W  rounds won in current game, saturating.
- busy  out  1  1 in WAIT, LIT, JUDGE.
- game_over  out  1  1 in OVER.

Behaviour:
- FSM states: IDLE, WAIT, LIT, JUDGE, OVER. Cycle counter `cnt` is sized for max(WAIT_CYC, WIN_CYC); `result` is a 1-bit register.
- Outputs are decoded from the state register (Moore), except `score`, which is a register:
  - led = (LIT)
  - dec_en = (JUDGE)
  - dec_d = (JUDGE) & result
  - busy = WAIT|LIT|JUDGE
  - game_over = (OVER)
- Reset asserted (reset = 0): immediately, regardless of clk:
  - state = IDLE, cnt = 0, result = 0, score = 0.
  - All outputs 0.
  - Applies in any state, including mid-round and during JUDGE; no `dec_en` is issued.
- IDLE: start = 1 -> WAIT, cnt = 0, score = 0.
- WAIT (led = 0):
  - btn = 1 -> JUDGE with result = 0 (false start).
  - Otherwise, if cnt == WAIT_CYC-1 -> LIT, cnt = 0.
  - Otherwise cnt+1.
  - btn on the final WAIT cycle is still a false start: btn beats expiry.
- LIT (led = 1):
  - btn = 1 -> JUDGE with result = 1.
  - Otherwise, if cnt == WIN_CYC-1 -> JUDGE with result = 0 (timeout).
  - Otherwise cnt+1.
  - btn on the final LIT cycle wins: btn beats expiry.
  - LED is high exactly WIN_CYC cycles when no press occurs.
- JUDGE: lasts exactly one cycle; dec_en = 1, dec_d = result.
  - result = 1: score+1, saturating at 2^SCORE_W-1; next state WAIT, cnt = 0 (next round).
  - result = 0: score unchanged; next state OVER.
- OVER: game_over = 1, score held. start = 1 -> WAIT, cnt = 0, score = 0.
- start while busy is ignored.
- btn held across JUDGE into the next WAIT counts as a false start on the first WAIT cycle. Players must release; no edge detection is done here.
- Latency:
  - btn sampled high at edge t -> dec_en high for cycle t..t+1.
  - Score update is visible after edge t+1.
  - A win leads to the next LIT WAIT_CYC cycles after JUDGE.
- No other outputs toggle outside the listed states.

Test Plan:
1. Reset mid-round: assert reset = 0 during LIT with score = 2 -> led = 0, dec_en = 0, score = 0, busy = 0 asynchronously. After release, the block stays in IDLE until start.
2. Win round (defaults): start pulse; btn high on 3rd LIT cycle -> dec_en = 1 and dec_d = 1 for exactly one cycle; score = 1; led low 16 cycles, then high again.
3. Timeout loss: start, never press -> led high exactly 8 cycles, then dec_en = 1 with dec_d = 0; then game_over = 1, busy = 0, score = 0 held.
4. False start: btn high on WAIT cycle 5 (and separately on cycle 16, the last) -> dec_en with dec_d = 0, led never asserted, game_over = 1.
5. Boundary and saturation:
   - btn on 8th (last) LIT cycle -> dec_d = 1 win.
   - 17 consecutive wins with SCORE_W = 4 -> score stops at 15; every strobe has dec_d = 1.
6. Start handling:
   - start pulsed during WAIT/LIT -> ignored, round timing unchanged.
   - start in OVER with score = 3 -> score = 0, busy = 1, WAIT entered next cycle.
